dist_frame_buffer: RTL and testbench
====================================

Name: dist_frame_buffer

Overview:
- Sits directly downstream of the per-point distance calculator.
- Each time the calculator pulses i_dist_new_sig, this block captures that point's distance and RSSI.
- It collects all points of one scan revolution (start index to stop index) into one bank of a ping-pong buffer.
- At the end of the scan it publishes the completed frame, with its point count, to the network packer (W5500 path), which reads it out by address and then releases it.

Parameters:
- DEPTH, 2048: points per bank; a power of two.
- ADDR_W, 11: log2(DEPTH); width of the read address.
- ANGLE_MARGIN, 10: code-angle guard added to the start/stop indices.

Ports:
- i_clk_50m  in  1  system clock (50 MHz).
- i_rst  in  1  synchronous active-high reset.
- i_start_index  in  16  first code angle of the scan window.
- i_stop_index  in  16  last code angle of the scan window.
- i_code_angle  in  16  current encoder angle.
- i_dist_data  in  16  distance of the current point.
- i_rssi_data  in  16  pulse width (RSSI) of the current point.
- i_dist_new_sig  in  1  one-cycle strobe: point valid.
- i_rd_addr  in  ADDR_W  read address within the published frame.
- o_rd_data  out  32  {dist[15:0], rssi[15:0]} at i_rd_addr, registered.
- i_frame_done  in  1  one-cycle strobe: reader releases the published frame.
- o_frame_ready  out  1  level: a published frame is available.
- o_frame_points  out  ADDR_W+1  number of valid points in the published frame.
- o_overflow  out  1  published frame had more than DEPTH strobes.
- o_drop_cnt  out  16  frames dropped because the reader was busy; saturating.
- o_frame_sum  out  16  checksum of the published frame (see Optional Feature).

Behaviour:
- Clock and reset: one clock, i_clk_50m. i_rst is synchronous and active-high.
- Reset values: all outputs 0; state W_WRAP; write bank 0; write pointer 0; no frame published.
- Reset mid-frame: the partial frame and any published frame are discarded. o_frame_ready goes 0 on the cycle after i_rst is sampled high.
- Angle compares: 16-bit unsigned. Sums are truncated to 16 bits.

State machine:
- W_WRAP
  - Waits for the start of a new revolution: i_code_angle < i_start_index.
  - Then goes to W_ARM.
- W_ARM
  - When i_code_angle + ANGLE_MARGIN >= i_start_index: clear write pointer, the sticky overflow flag and the running sum; go to W_COLLECT.
- W_COLLECT, on each cycle with i_dist_new_sig=1:
  - If write pointer < DEPTH: write {i_dist_data, i_rssi_data} to write_bank*DEPTH + pointer, then increment the pointer.
  - Otherwise: discard the point and set the internal overflow flag.
- W_COLLECT, frame end:
  - Frame end is when i_code_angle >= i_stop_index + ANGLE_MARGIN. Go to W_PUBLISH.
  - A strobe in the same cycle as the frame-end condition is stored and counted in this frame.
- W_PUBLISH (one cycle), then W_WRAP:
  - If the reader is free (o_frame_ready=0 after any same-cycle release):
    - Next cycle: o_frame_ready=1; o_frame_points=pointer; o_overflow=flag; o_frame_sum=sum.
    - The read bank becomes the write bank, and the write bank toggles.
  - If the reader is busy: the frame is dropped. o_drop_cnt increments, saturating at 16'hFFFF. The write bank is reused. Published outputs are unchanged.
- Strobes outside W_COLLECT are ignored.

Read side:
- o_rd_data is valid one cycle after i_rd_addr, from the published bank.
- Addresses >= o_frame_points return stale contents; there is no check.
- i_frame_done while o_frame_ready=1: o_frame_ready=0 next cycle.
  - o_frame_points, o_overflow and o_frame_sum hold their values until the next publish.
- i_frame_done while o_frame_ready=0: ignored.
- i_frame_done in the same cycle as W_PUBLISH: the release applies first. The new frame is published, o_frame_ready stays 1, and the count and sum update.

Storage: 2*DEPTH x 32 memory with one write port and one synchronous read port; inferable as block RAM.

Optional Feature:
- Macro: FRAME_SUM_EN.
- Defined:
  - Running sum = sum of (dist + rssi) over stored points, mod 2^16.
  - Cleared in W_ARM; latched to o_frame_sum at publish.
  - Discarded overflow points are excluded.
- Undefined: the sum logic is absent and o_frame_sum is tied to 0.

Test Plan:
- Basic frame: start=100, stop=200. Sweep angle 0->300, strobing at every angle 90..210 with dist=angle, rssi=500.
  - Expect o_frame_ready=1 at angle 210; o_frame_points=121.
  - Read addr 0 -> 32'h005A_01F4 one cycle later; addr 120 -> 32'h00D2_01F4.
- Overflow: DEPTH=16, 20 strobes in the window.
  - Expect o_frame_points=16, o_overflow=1; addr 15 holds the 16th point.
  - Next frame with 5 strobes: expect o_overflow=0.
- Reader busy: publish frame A and withhold i_frame_done; complete frame B.
  - Expect o_drop_cnt=1; o_frame_points and data still those of A.
  - Pulse i_frame_done: expect ready=0; frame C publishes normally into the other bank.
- Same-cycle release: assert i_frame_done in the W_PUBLISH cycle of frame B.
  - Expect o_frame_ready to stay 1, o_frame_points = B's count, o_drop_cnt unchanged.
- Reset mid-collect: i_rst high for 1 cycle after 50 strobes.
  - Expect all outputs 0. Data collection resumes only after the angle wraps below start and re-arms.
- FRAME_SUM_EN: 3 points (dist 1000/2000/65000, rssi 600 each).
  - Expect o_frame_sum = (69800) mod 65536 = 16'h10A8; 0 when the macro is undefined.

Source files
------------

// File: rtl/dist_frame_buffer.sv
// dist_frame_buffer: captures per-point {distance, rssi} samples for one scan
// revolution into one half of a ping-pong RAM, then hands the finished frame
// (point count, overflow flag, optional checksum) to the network packer,
// which reads it out by address and releases it with i_frame_done.
// Optional feature macro: FRAME_SUM_EN (per-frame 16-bit running checksum).
module dist_frame_buffer #(
    parameter int DEPTH        = 2048,
    parameter int ADDR_W       = 11,
    parameter int ANGLE_MARGIN = 10
) (
    input  logic              i_clk_50m,
    input  logic              i_rst,
    input  logic [15:0]       i_start_index,
    input  logic [15:0]       i_stop_index,
    input  logic [15:0]       i_code_angle,
    input  logic [15:0]       i_dist_data,
    input  logic [15:0]       i_rssi_data,
    input  logic              i_dist_new_sig,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [31:0]       o_rd_data,
    input  logic              i_frame_done,
    output logic              o_frame_ready,
    output logic [ADDR_W:0]   o_frame_points,
    output logic              o_overflow,
    output logic [15:0]       o_drop_cnt,
    output logic [15:0]       o_frame_sum
);

    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [15:0]     MARGIN_L = 16'(ANGLE_MARGIN);

    typedef enum logic [1:0] {
        W_WRAP,
        W_ARM,
        W_COLLECT,
        W_PUBLISH
    } state_t;

    state_t              state_reg;
    logic                wr_bank_reg;
    logic                rd_bank_reg;
    logic [ADDR_W:0]     wr_ptr_reg;
    logic                ovf_flag_reg;
    logic                frame_ready_reg;
    logic [ADDR_W:0]     frame_points_reg;
    logic                overflow_reg;
    logic [15:0]         drop_cnt_reg;
    logic [31:0]         rd_data_reg;

    logic [31:0]         mem [0:2*DEPTH-1];

    logic [15:0]         arm_angle;
    logic [15:0]         end_angle;
    logic                arm_hit;
    logic                frame_end;
    logic                collect_stb;
    logic                store_en;
    logic                publish_ok;
    logic                publish_drop;
    logic [ADDR_W:0]     wr_addr;
    logic [ADDR_W:0]     rd_addr_full;

    // Angle guards are plain 16-bit unsigned sums (wrap on overflow).
    assign arm_angle    = i_code_angle + MARGIN_L;
    assign end_angle    = i_stop_index + MARGIN_L;
    assign arm_hit      = (state_reg == W_ARM) && (arm_angle >= i_start_index);
    assign frame_end    = (i_code_angle >= end_angle);
    assign collect_stb  = (state_reg == W_COLLECT) && i_dist_new_sig;
    assign store_en     = collect_stb && (wr_ptr_reg < DEPTH_L);
    // A release arriving in the publish cycle frees the reader first.
    assign publish_ok   = (state_reg == W_PUBLISH) && (!frame_ready_reg || i_frame_done);
    assign publish_drop = (state_reg == W_PUBLISH) && frame_ready_reg && !i_frame_done;
    assign wr_addr      = {wr_bank_reg, wr_ptr_reg[ADDR_W-1:0]};
    assign rd_addr_full = {rd_bank_reg, i_rd_addr};

    // Capture FSM plus the published-frame descriptor registers.
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            state_reg        <= W_WRAP;
            wr_bank_reg      <= 1'b0;
            rd_bank_reg      <= 1'b0;
            wr_ptr_reg       <= '0;
            ovf_flag_reg     <= 1'b0;
            frame_ready_reg  <= 1'b0;
            frame_points_reg <= '0;
            overflow_reg     <= 1'b0;
            drop_cnt_reg     <= 16'h0;
        end else begin
            if (i_frame_done && frame_ready_reg) begin
                frame_ready_reg <= 1'b0;
            end
            case (state_reg)
                W_WRAP: begin
                    if (i_code_angle < i_start_index) begin
                        state_reg <= W_ARM;
                    end
                end
                W_ARM: begin
                    if (arm_hit) begin
                        wr_ptr_reg   <= '0;
                        ovf_flag_reg <= 1'b0;
                        state_reg    <= W_COLLECT;
                    end
                end
                W_COLLECT: begin
                    if (store_en) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    end else if (collect_stb) begin
                        ovf_flag_reg <= 1'b1;
                    end
                    if (frame_end) begin
                        state_reg <= W_PUBLISH;
                    end
                end
                W_PUBLISH: begin
                    if (publish_ok) begin
                        frame_ready_reg  <= 1'b1;
                        frame_points_reg <= wr_ptr_reg;
                        overflow_reg     <= ovf_flag_reg;
                        rd_bank_reg      <= wr_bank_reg;
                        wr_bank_reg      <= ~wr_bank_reg;
                    end else if (publish_drop && (drop_cnt_reg != 16'hFFFF)) begin
                        drop_cnt_reg <= drop_cnt_reg + 16'h1;
                    end
                    state_reg <= W_WRAP;
                end
                default: state_reg <= W_WRAP;
            endcase
        end
    end

    // Write port of the ping-pong RAM (no reset so it maps to block RAM).
    always_ff @(posedge i_clk_50m) begin
        if (store_en) begin
            mem[wr_addr] <= {i_dist_data, i_rssi_data};
        end
    end

    // Registered read port from the published bank.
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            rd_data_reg <= 32'h0;
        end else begin
            rd_data_reg <= mem[rd_addr_full];
        end
    end

`ifdef FRAME_SUM_EN
    logic [15:0] sum_reg;
    logic [15:0] frame_sum_reg;

    // Running checksum of stored points, latched alongside the descriptor.
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            sum_reg       <= 16'h0;
            frame_sum_reg <= 16'h0;
        end else begin
            if (arm_hit) begin
                sum_reg <= 16'h0;
            end else if (store_en) begin
                sum_reg <= sum_reg + i_dist_data + i_rssi_data;
            end
            if (publish_ok) begin
                frame_sum_reg <= sum_reg;
            end
        end
    end

    assign o_frame_sum = frame_sum_reg;
`else
    assign o_frame_sum = 16'h0;
`endif

    assign o_rd_data      = rd_data_reg;
    assign o_frame_ready  = frame_ready_reg;
    assign o_frame_points = frame_points_reg;
    assign o_overflow     = overflow_reg;
    assign o_drop_cnt     = drop_cnt_reg;

endmodule

// File: tb/tb_dist_frame_buffer.sv
// tb_dist_frame_buffer: directed bench for dist_frame_buffer. A full-size
// instance (DEPTH 2048) and a small one (DEPTH 16) share all stimulus; the
// small one exercises the overflow path. Scan window: start 100, stop 200.
module tb_dist_frame_buffer;

    logic        clk;
    logic        rst;
    logic [15:0] start_index;
    logic [15:0] stop_index;
    logic [15:0] code_angle;
    logic [15:0] dist_data;
    logic [15:0] rssi_data;
    logic        dist_new_sig;
    logic [10:0] rd_addr;
    logic        frame_done;

    logic [31:0] b_rd_data;
    logic        b_ready;
    logic [11:0] b_points;
    logic        b_overflow;
    logic [15:0] b_drop;
    logic [15:0] b_sum;

    logic [31:0] s_rd_data;
    logic        s_ready;
    logic [4:0]  s_points;
    logic        s_overflow;
    logic [15:0] s_drop;
    logic [15:0] s_sum;

    int n_checks;
    int n_errors;

    logic [15:0] pd [0:31];
    logic [15:0] pr [0:31];

`ifdef FRAME_SUM_EN
    localparam logic [15:0] SUM_EXP = 16'h10A8;
`else
    localparam logic [15:0] SUM_EXP = 16'h0000;
`endif

    dist_frame_buffer #(.DEPTH(2048), .ADDR_W(11), .ANGLE_MARGIN(10)) u_big (
        .i_clk_50m      (clk),
        .i_rst          (rst),
        .i_start_index  (start_index),
        .i_stop_index   (stop_index),
        .i_code_angle   (code_angle),
        .i_dist_data    (dist_data),
        .i_rssi_data    (rssi_data),
        .i_dist_new_sig (dist_new_sig),
        .i_rd_addr      (rd_addr),
        .o_rd_data      (b_rd_data),
        .i_frame_done   (frame_done),
        .o_frame_ready  (b_ready),
        .o_frame_points (b_points),
        .o_overflow     (b_overflow),
        .o_drop_cnt     (b_drop),
        .o_frame_sum    (b_sum)
    );

    dist_frame_buffer #(.DEPTH(16), .ADDR_W(4), .ANGLE_MARGIN(10)) u_small (
        .i_clk_50m      (clk),
        .i_rst          (rst),
        .i_start_index  (start_index),
        .i_stop_index   (stop_index),
        .i_code_angle   (code_angle),
        .i_dist_data    (dist_data),
        .i_rssi_data    (rssi_data),
        .i_dist_new_sig (dist_new_sig),
        .i_rd_addr      (rd_addr[3:0]),
        .o_rd_data      (s_rd_data),
        .i_frame_done   (frame_done),
        .o_frame_ready  (s_ready),
        .o_frame_points (s_points),
        .o_overflow     (s_overflow),
        .o_drop_cnt     (s_drop),
        .o_frame_sum    (s_sum)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // One clock: inputs applied at a falling edge, outputs visible at the next.
    task automatic cyc(input logic [15:0] ang, input logic stb, input logic [15:0] d,
                       input logic [15:0] r, input logic done);
        code_angle   = ang;
        dist_new_sig = stb;
        dist_data    = d;
        rssi_data    = r;
        frame_done   = done;
        @(negedge clk);
        dist_new_sig = 1'b0;
        frame_done   = 1'b0;
    endtask

    task automatic rd(input logic [10:0] a);
        rd_addr = a;
        @(negedge clk);
    endtask

    task automatic fill(input logic [15:0] base, input logic [15:0] r, input int n);
        for (int i = 0; i < n; i++) begin
            pd[i] = base + 16'(i);
            pr[i] = r;
        end
    endtask

    // Wrap, arm, n strobes (last one on the frame-end cycle), publish cycle.
    task automatic frame(input int n, input logic done_pub);
        cyc(16'd0, 1'b0, 16'd0, 16'd0, 1'b0);
        cyc(16'd90, 1'b0, 16'd0, 16'd0, 1'b0);
        for (int i = 0; i < n - 1; i++) begin
            cyc(16'd150, 1'b1, pd[i], pr[i], 1'b0);
        end
        cyc(16'd210, 1'b1, pd[n-1], pr[n-1], 1'b0);
        cyc(16'd220, 1'b0, 16'd0, 16'd0, done_pub);
    endtask

    task automatic release_frame();
        cyc(16'd250, 1'b0, 16'd0, 16'd0, 1'b1);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        start_index  = 16'd100;
        stop_index   = 16'd200;
        code_angle   = 16'd0;
        dist_data    = 16'd0;
        rssi_data    = 16'd0;
        dist_new_sig = 1'b0;
        rd_addr      = 11'd0;
        frame_done   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_ready",    32'(b_ready),    32'd0);
        check("rst_points",   32'(b_points),   32'd0);
        check("rst_overflow", 32'(b_overflow), 32'd0);
        check("rst_drop",     32'(b_drop),     32'd0);
        check("rst_sum",      32'(b_sum),      32'd0);
        check("rst_rd_data",  b_rd_data,       32'd0);

        // Basic frame: angle sweep, each angle held two clocks. The point for
        // angles 90..209 arrives on the second clock; the closing angle's
        // point arrives with the angle update, i.e. on the frame-end clock.
        for (int a = 0; a <= 210; a++) begin
            cyc(16'(a), (a == 210), 16'(a), 16'd500, 1'b0);
            cyc(16'(a), (a >= 90 && a < 210), 16'(a), 16'd500, 1'b0);
            if (a == 209) check("basic_ready_pre", 32'(b_ready), 32'd0);
        end
        check("basic_ready",    32'(b_ready),    32'd1);
        check("basic_points",   32'(b_points),   32'd121);
        check("basic_overflow", 32'(b_overflow), 32'd0);
        rd(11'd0);
        check("basic_addr0",    b_rd_data, 32'h005A_01F4);
        rd(11'd120);
        check("basic_addr120",  b_rd_data, 32'h00D2_01F4);
        check("small_points121", 32'(s_points),   32'd16);
        check("small_ovf121",    32'(s_overflow), 32'd1);
        rd(11'd15);
        check("small_addr15",    s_rd_data, 32'h0069_01F4);
        release_frame();
        check("basic_released",  32'(b_ready),  32'd0);
        check("basic_hold_pts",  32'(b_points), 32'd121);

        // Overflow: 20 strobes into a 16-deep bank
        fill(16'd1000, 16'd7, 20);
        frame(20, 1'b0);
        check("ovf_points",    32'(s_points),   32'd16);
        check("ovf_flag",      32'(s_overflow), 32'd1);
        check("ovf_big_pts",   32'(b_points),   32'd20);
        check("ovf_big_flag",  32'(b_overflow), 32'd0);
        rd(11'd15);
        check("ovf_addr15",    s_rd_data, {16'd1015, 16'd7});
        release_frame();
        fill(16'd2000, 16'd7, 5);
        frame(5, 1'b0);
        check("ovf_next_flag", 32'(s_overflow), 32'd0);
        check("ovf_next_pts",  32'(s_points),   32'd5);
        release_frame();

        // Reader busy: A published and held, B dropped, C after release
        fill(16'd3000, 16'd1, 4);
        frame(4, 1'b0);
        check("busy_a_ready",  32'(b_ready), 32'd1);
        fill(16'd4000, 16'd2, 6);
        frame(6, 1'b0);
        check("busy_drop",     32'(b_drop),   32'd1);
        check("busy_a_points", 32'(b_points), 32'd4);
        rd(11'd0);
        check("busy_a_data",   b_rd_data, {16'd3000, 16'd1});
        release_frame();
        check("busy_released", 32'(b_ready), 32'd0);
        fill(16'd5000, 16'd3, 3);
        frame(3, 1'b0);
        check("busy_c_ready",  32'(b_ready),  32'd1);
        check("busy_c_points", 32'(b_points), 32'd3);
        check("busy_c_drop",   32'(b_drop),   32'd1);
        rd(11'd0);
        check("busy_c_data",   b_rd_data, {16'd5000, 16'd3});

        // Same-cycle release in the publish cycle
        fill(16'd6000, 16'd4, 7);
        frame(7, 1'b1);
        check("same_ready",  32'(b_ready),  32'd1);
        check("same_points", 32'(b_points), 32'd7);
        check("same_drop",   32'(b_drop),   32'd1);
        rd(11'd6);
        check("same_data6",  b_rd_data, {16'd6006, 16'd4});
        release_frame();

        // Checksum frame (left published for the reset test)
        pd[0] = 16'd1000;  pr[0] = 16'd600;
        pd[1] = 16'd2000;  pr[1] = 16'd600;
        pd[2] = 16'd65000; pr[2] = 16'd600;
        frame(3, 1'b0);
        check("sum_big",   32'(b_sum), 32'(SUM_EXP));
        check("sum_small", 32'(s_sum), 32'(SUM_EXP));

        // Reset mid-collect after 50 strobes
        cyc(16'd0, 1'b0, 16'd0, 16'd0, 1'b0);
        cyc(16'd90, 1'b0, 16'd0, 16'd0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            cyc(16'd150, 1'b1, 16'(8000 + i), 16'd5, 1'b0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ready",   32'(b_ready),    32'd0);
        check("mid_rst_points",  32'(b_points),   32'd0);
        check("mid_rst_ovf",     32'(b_overflow), 32'd0);
        check("mid_rst_drop",    32'(b_drop),     32'd0);
        check("mid_rst_sum",     32'(b_sum),      32'd0);
        check("mid_rst_rd_data", b_rd_data,       32'd0);
        // Angle still inside the window: no collection until it wraps
        for (int i = 0; i < 5; i++) begin
            cyc(16'd150, 1'b1, 16'd9000, 16'd9, 1'b0);
        end
        cyc(16'd210, 1'b1, 16'd9000, 16'd9, 1'b0);
        cyc(16'd220, 1'b0, 16'd0, 16'd0, 1'b0);
        check("mid_rst_no_pub",  32'(b_ready), 32'd0);
        fill(16'd7000, 16'd9, 2);
        frame(2, 1'b0);
        check("resume_ready",  32'(b_ready),  32'd1);
        check("resume_points", 32'(b_points), 32'd2);
        rd(11'd0);
        check("resume_data0",  b_rd_data, {16'd7000, 16'd9});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
